// File: rtl/csa_pipe_if.sv
// Operand/result bundle for csa_pipe: valid-ready on both sides.
// The slave modport faces the adder; the master faces its driver.
interface csa_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/csa_pipe.sv
// Two-stage carry-select adder; signed overflow flag enabled by CSA_PIPE_OVF_EN.
// Latency: two edges from input presentation to result; one beat per cycle.
// Backpressure: stalled result holds, S1 holds one more beat, then in_ready drops.
module csa_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic       clk,
  input  logic       rst,
  csa_pipe_if.slave  bus
);
  localparam bit CFG_OK = (WIDTH > 0) && (BLOCK > 0) &&
                          ((WIDTH % ((BLOCK > 0) ? BLOCK : 1)) == 0);
  localparam int NB     = (BLOCK > 0) ? WIDTH / BLOCK : 1;

  if (!CFG_OK) begin : g_bad_cfg
    $error("csa_pipe: WIDTH must be a positive multiple of BLOCK");
  end

  logic [NB-1:0][BLOCK-1:0] blk_sum0, blk_sum1;
  logic [NB-1:0]            blk_c0, blk_c1;
  logic [NB-1:0][BLOCK-1:0] s1_sum0, s1_sum1;
  logic [NB-1:0]            s1_c0, s1_c1;
  logic                     s1_valid;
  logic [NB:0]              csel;
  logic [WIDTH-1:0]         nxt_sum;
  logic [WIDTH-1:0]         sum_q;
  logic                     carry_q;
  logic                     out_valid_q;
  logic                     in_ready_c;
  logic                     s2_load;

  // Stage 1: every block adds independently; no carry crosses a block here.
  for (genvar i = 0; i < NB; i++) begin : g_blk
    logic [BLOCK-1:0] op_a, op_b;
    assign op_a = bus.a[i*BLOCK +: BLOCK];
    assign op_b = bus.b[i*BLOCK +: BLOCK];
    if (i == 0) begin : g_lsb
      assign {blk_c0[i], blk_sum0[i]} = {1'b0, op_a} + {1'b0, op_b} + {{BLOCK{1'b0}}, bus.cin};
      assign blk_c1[i]   = 1'b0;
      assign blk_sum1[i] = '0;
    end else begin : g_hi
      assign {blk_c0[i], blk_sum0[i]} = {1'b0, op_a} + {1'b0, op_b};
      assign {blk_c1[i], blk_sum1[i]} = {1'b0, op_a} + {1'b0, op_b} + {{BLOCK{1'b0}}, 1'b1};
    end
  end

  // Stage 2: select chain; csel[0] is tied low so block 0 always takes its real result.
  always_comb begin
    csel    = '0;
    nxt_sum = '0;
    for (int k = 0; k < NB; k++) begin
      nxt_sum[k*BLOCK +: BLOCK] = csel[k] ? s1_sum1[k] : s1_sum0[k];
      csel[k+1]                 = csel[k] ? s1_c1[k]   : s1_c0[k];
    end
  end

  assign in_ready_c = !s1_valid || !out_valid_q || bus.out_ready;
  assign s2_load    = s1_valid && (!out_valid_q || bus.out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
    end else begin
      if (in_ready_c)
        s1_valid <= bus.in_valid;
      if (s2_load) begin
        out_valid_q <= 1'b1;
        sum_q       <= nxt_sum;
        carry_q     <= csel[NB];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready_c) begin
      s1_sum0 <= blk_sum0;
      s1_sum1 <= blk_sum1;
      s1_c0   <= blk_c0;
      s1_c1   <= blk_c1;
    end
  end

`ifdef CSA_PIPE_OVF_EN
  logic s1_a_msb, s1_b_msb, ovf_q;

  always_ff @(posedge clk) begin
    if (in_ready_c) begin
      s1_a_msb <= bus.a[WIDTH-1];
      s1_b_msb <= bus.b[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (s2_load)
      ovf_q <= (s1_a_msb == s1_b_msb) && (nxt_sum[WIDTH-1] != s1_a_msb);
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
endmodule

// File: tb/tb_csa_pipe.sv
// Directed bench for csa_pipe (WIDTH=16, BLOCK=4): vector table plus
// hand-written stall and mid-flight reset sequences.
module tb_csa_pipe;
`ifdef CSA_PIPE_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } vec_t;

  localparam int NV = 10;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vecs [NV];

  csa_pipe_if #(.WIDTH(16)) bus ();

  csa_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    int sent;
    int got;
    int stall_left;
    bit seen_first;
    bit acc;
    int extra;

    n_tests = 0;
    n_fail  = 0;

    //          a         b         cin   sum       carry ovf
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};
    vecs[7] = '{16'hABCD, 16'h5433, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[9] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum",       32'(bus.sum),       32'h0);
    chk("rst_carry",     32'(bus.carry),     32'd0);
    chk("rst_overflow",  32'(bus.overflow),  32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Single beats: result visible two edges after presentation
    for (int v = 0; v < NV; v++) begin
      bus.a        = vecs[v].a;
      bus.b        = vecs[v].b;
      bus.cin      = vecs[v].cin;
      bus.in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", v), 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_lat1_valid", v), 32'(bus.out_valid), 32'd0);
      step();
      chk($sformatf("v%0d_valid", v), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_sum", v),   32'(bus.sum),       32'(vecs[v].sum));
      chk($sformatf("v%0d_carry", v), 32'(bus.carry),     32'(vecs[v].carry));
      chk($sformatf("v%0d_ovf", v),   32'(bus.overflow),  32'(vecs[v].ovf & OVF_EN));
      step();
      chk($sformatf("v%0d_drained", v), 32'(bus.out_valid), 32'd0);
    end

    // Back-to-back throughput with out_ready held high
    for (int c = 0; c < NV + 2; c++) begin
      if (c < NV) begin
        bus.a        = vecs[c].a;
        bus.b        = vecs[c].b;
        bus.cin      = vecs[c].cin;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c >= 2) begin
        chk($sformatf("bb%0d_valid", c - 2), 32'(bus.out_valid), 32'd1);
        chk($sformatf("bb%0d_sum", c - 2),   32'(bus.sum),       32'(vecs[c-2].sum));
        chk($sformatf("bb%0d_carry", c - 2), 32'(bus.carry),     32'(vecs[c-2].carry));
      end
      step();
    end
    step();
    chk("bb_drained", 32'(bus.out_valid), 32'd0);

    // Stall: 1+1..4+4, out_ready low for three cycles after the first result
    sent         = 0;
    got          = 0;
    stall_left   = 3;
    seen_first   = 1'b0;
    bus.a        = 16'd1;
    bus.b        = 16'd1;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (bus.out_valid && !seen_first)
        seen_first = 1'b1;
      bus.out_ready = !(seen_first && stall_left > 0);
      #1;
      if (seen_first && stall_left > 0) begin
        chk($sformatf("stall%0d_sum", 3 - stall_left),      32'(bus.sum),       32'h0002);
        chk($sformatf("stall%0d_valid", 3 - stall_left),    32'(bus.out_valid), 32'd1);
        chk($sformatf("stall%0d_in_ready", 3 - stall_left), 32'(bus.in_ready),  32'd0);
        stall_left--;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("stream%0d_sum", got), 32'(bus.sum), 32'(2 * (got + 1)));
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) begin
        sent++;
        if (sent < 4) begin
          bus.a = 16'(sent + 1);
          bus.b = 16'(sent + 1);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    chk("stream_count", 32'(got), 32'd4);
    chk("stream_sent",  32'(sent), 32'd4);
    bus.out_ready = 1'b1;
    step();
    step();
    chk("stream_no_extra", 32'(bus.out_valid), 32'd0);

    // Reset with both stages full discards everything in flight
    bus.out_ready = 1'b0;
    bus.a         = 16'd5;
    bus.b         = 16'd5;
    bus.in_valid  = 1'b1;
    step();
    bus.a = 16'd7;
    bus.b = 16'd7;
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    chk("full_in_ready",  32'(bus.in_ready),  32'd0);
    rst = 1'b1;
    step();
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sum",       32'(bus.sum),       32'h0);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.out_valid)
        extra++;
    end
    chk("midrst_no_stale", 32'(extra), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
